// File: rtl/ram_seq_pkg.sv
// ram_seq_pkg: shared state type, widths and helpers for the RAM word sequencer.
// next_set() is only used by the RAM_SEQ_SKIP_MASKED_EN build of ram_word_sequencer.
package ram_seq_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = 2;
  localparam int DEFAULT_ADDR_W = 9;

  localparam logic [BYTE_IDX_W-1:0] LAST_K = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    RESP
  } seq_state_t;

  // Lowest set strobe at index >= from; bit 2 set means none left.
  function automatic logic [2:0] next_set(
    input logic [BYTES_PER_WORD-1:0] m,
    input logic [2:0]                from
  );
    logic [2:0] r;
    r = 3'b100;
    for (int i = BYTES_PER_WORD - 1; i >= 0; i--) begin
      if (m[i] && (3'(i) >= from)) begin
        r = {1'b0, 2'(i)};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_seq_rd_pipe.sv
// ram_seq_rd_pipe: delay line carrying {valid, byte index} for in-flight reads.
// A tag enters with its address and emerges when the RAM data is on ram_do.
module ram_seq_rd_pipe
  import ram_seq_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  tag_valid,
  input  logic [BYTE_IDX_W-1:0] tag_k,
  output logic                  cap_valid,
  output logic [BYTE_IDX_W-1:0] cap_k
);

  logic [DEPTH-1:0]                 v;
  logic [DEPTH-1:0][BYTE_IDX_W-1:0] k;

  // Shift one tag per cycle; reset empties the line.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      v <= '0;
      k <= '0;
    end else begin
      v[0] <= tag_valid;
      k[0] <= tag_k;
      for (int i = 1; i < DEPTH; i++) begin
        v[i] <= v[i-1];
        k[i] <= k[i-1];
      end
    end
  end

  assign cap_valid = v[DEPTH-1];
  assign cap_k     = k[DEPTH-1];

endmodule

// File: rtl/ram_word_sequencer.sv
// ram_word_sequencer: serialises 32-bit word requests onto the 8-bit RAM wrapper port.
// Define RAM_SEQ_SKIP_MASKED_EN to make writes visit only strobed bytes.
module ram_word_sequencer
  import ram_seq_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int RD_LATENCY = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_di,
  input  logic [7:0]        ram_do
);

  seq_state_t state;

  logic [BYTE_IDX_W-1:0] k;
  logic [BYTE_IDX_W-1:0] kn;
  logic [ADDR_W-1:0]     base;
  logic [ADDR_W-1:0]     req_base;
  logic [3:0][7:0]       wd_in;
  logic [3:0][7:0]       wdata;
  logic [3:0]            wstrb;
  logic [3:0][7:0]       rd_buf;
  logic [3:0][7:0]       buf_next;

  logic                  issue_valid;
  logic [BYTE_IDX_W-1:0] issue_k;
  logic                  cap_valid;
  logic [BYTE_IDX_W-1:0] cap_k;
  logic                  cap_last;

  assign kn        = k + 1'b1;
  assign wd_in     = req_wdata;
  assign req_base  = req_addr & ~ADDR_W'(3);
  assign cap_last  = cap_valid && (cap_k == LAST_K);
  assign req_ready = (state == IDLE) && RST_N;

  function automatic logic [ADDR_W-1:0] addr_of(
    input logic [ADDR_W-1:0]     b,
    input logic [BYTE_IDX_W-1:0] i
  );
    return b | ADDR_W'(i);
  endfunction

`ifdef RAM_SEQ_SKIP_MASKED_EN
  logic [2:0] first_set;
  logic [2:0] next_after;

  assign first_set  = next_set(req_wstrb, 3'd0);
  assign next_after = next_set(wstrb, {1'b0, k} + 3'd1);
`endif

  // Read tag issued in the same cycle its byte address is registered.
  always_comb begin
    issue_valid = 1'b0;
    issue_k     = '0;
    if (state == IDLE) begin
      issue_valid = req_valid && !req_we;
    end else if (state == READ) begin
      issue_valid = (k != LAST_K);
      issue_k     = kn;
    end
  end

  // Read buffer including the byte arriving this cycle.
  always_comb begin
    buf_next = rd_buf;
    if (cap_valid) begin
      buf_next[cap_k] = ram_do;
    end
  end

  ram_seq_rd_pipe #(
    .DEPTH(RD_LATENCY)
  ) u_rd_pipe (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .tag_valid(issue_valid),
    .tag_k    (issue_k),
    .cap_valid(cap_valid),
    .cap_k    (cap_k)
  );

  // Sequencer FSM with registered RAM-side and response outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      k         <= '0;
      base      <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      rd_buf    <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_di    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rd_buf <= buf_next;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            base  <= req_base;
            wdata <= wd_in;
            wstrb <= req_wstrb;
            if (req_we) begin
`ifdef RAM_SEQ_SKIP_MASKED_EN
              if (first_set[2]) begin
                state     <= RESP;
                rsp_valid <= 1'b1;
                rsp_rdata <= '0;
              end else begin
                state    <= WRITE;
                k        <= first_set[1:0];
                ram_addr <= addr_of(req_base, first_set[1:0]);
                ram_di   <= wd_in[first_set[1:0]];
                ram_we   <= 1'b1;
              end
`else
              state    <= WRITE;
              k        <= '0;
              ram_addr <= req_base;
              ram_di   <= wd_in[0];
              ram_we   <= req_wstrb[0];
`endif
            end else begin
              state    <= READ;
              k        <= '0;
              ram_addr <= req_base;
              ram_we   <= 1'b0;
            end
          end
        end
        WRITE: begin
`ifdef RAM_SEQ_SKIP_MASKED_EN
          if (next_after[2]) begin
            state     <= RESP;
            ram_we    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            k        <= next_after[1:0];
            ram_addr <= addr_of(base, next_after[1:0]);
            ram_di   <= wdata[next_after[1:0]];
            ram_we   <= 1'b1;
          end
`else
          if (k == LAST_K) begin
            state     <= RESP;
            ram_we    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            k        <= kn;
            ram_addr <= addr_of(base, kn);
            ram_di   <= wdata[kn];
            ram_we   <= wstrb[kn];
          end
`endif
        end
        READ: begin
          if (k == LAST_K) begin
            if (cap_last) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= buf_next;
            end else begin
              state <= DRAIN;
            end
          end else begin
            k        <= kn;
            ram_addr <= addr_of(base, kn);
          end
        end
        DRAIN: begin
          if (cap_last) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= buf_next;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_word_sequencer.sv
// tb_ram_word_sequencer: directed and random word requests against a byte-RAM model.
// Honours RAM_SEQ_SKIP_MASKED_EN when computing expected write traffic.
module tb_ram_word_sequencer;

  localparam int AW  = 9;
  localparam int LAT = 2;

  logic          CLK       = 1'b0;
  logic          RST_N     = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we    = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [31:0]   req_wdata = '0;
  logic [3:0]    req_wstrb = '0;
  logic          rsp_ready = 1'b0;
  logic          load      = 1'b1;
  logic          req_ready;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_di;
  logic [7:0]    ram_do;

  logic [7:0] mem     [512];
  logic [7:0] ref_mem [512];

  int n_cmp = 0;
  int n_bad = 0;

  ram_word_sequencer #(
    .ADDR_W    (AW),
    .RD_LATENCY(LAT)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_di   (ram_di),
    .ram_do   (ram_do)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] seed(input int i);
    return 8'((i * 29 + 7) ^ (i >> 3));
  endfunction

  // Wrapper model: byte addressed on one cycle is on ram_do the next.
  always @(posedge CLK) begin
    if (load) begin
      for (int i = 0; i < 512; i++) mem[i] <= seed(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_di;
    end
    ram_do <= mem[ram_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_di", 32'(ram_di), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_req_ready", 32'(req_ready), 0);
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic do_req(input logic we, input logic [AW-1:0] addr,
                        input logic [31:0] wd, input logic [3:0] ws,
                        input int stall);
    int          ks[$];
    int          base;
    int          n;
    int          lat;
    bit          got;
    logic [31:0] exp_rd;
    base = int'(addr) & 'h1FC;
    for (int k = 0; k < 4; k++) begin
`ifdef RAM_SEQ_SKIP_MASKED_EN
      if (!we || ws[k]) ks.push_back(k);
`else
      ks.push_back(k);
`endif
    end
    if (we) lat = (ks.size() == 0) ? 1 : ks.size() + 1;
    else lat = 4 + LAT;
    exp_rd = '0;
    for (int k = 0; k < 4; k++) begin
      if (!we) exp_rd[8*k +: 8] = ref_mem[base + k];
      else if (ws[k]) ref_mem[base + k] = wd[8*k +: 8];
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_wstrb = ws;
    rsp_ready = 1'b0;
    @(negedge CLK);
    chk("req_ready_idle", 32'(req_ready), 1);
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = $urandom;
    req_wstrb = 4'($urandom);
    n   = 0;
    got = 0;
    while (!got && n < 30) begin
      @(negedge CLK);
      n++;
      if (n <= ks.size()) begin
        int k;
        k = ks[n-1];
        chk("ram_addr", 32'(ram_addr), base + k);
        chk("ram_we", 32'(ram_we), 32'(we & ws[k]));
        if (we) chk("ram_di", 32'(ram_di), 32'(wd[8*k +: 8]));
      end else begin
        chk("ram_we_idle", 32'(ram_we), 0);
      end
      if (rsp_valid) got = 1;
    end
    chk("rsp_latency", n, lat);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    for (int s = 0; s < stall; s++) begin
      @(posedge CLK);
      #1;
      req_valid = (s == 1);
      req_we    = 1'($urandom);
      req_addr  = AW'($urandom);
      @(negedge CLK);
      chk("hold_valid", 32'(rsp_valid), 1);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_req_ready", 32'(req_ready), 0);
      chk("hold_ram_we", 32'(ram_we), 0);
    end
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge CLK);
    chk("hs_valid", 32'(rsp_valid), 1);
    chk("hs_req_ready", 32'(req_ready), 0);
    @(posedge CLK);
    #1;
    rsp_ready = 1'b0;
    @(negedge CLK);
    chk("post_hs_valid", 32'(rsp_valid), 0);
    chk("post_hs_req_ready", 32'(req_ready), 1);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = seed(i);
    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk_reset_outputs();
    @(posedge CLK);
    #1;
    load  = 1'b0;
    RST_N = 1'b1;
    @(negedge CLK);
    chk("req_ready_out_of_reset", 32'(req_ready), 1);
    @(posedge CLK);
    #1;

    do_req(1'b1, 9'h010, 32'hDDCCBBAA, 4'hF, 0);
    do_req(1'b0, 9'h010, 32'h0, 4'h0, 0);
    do_req(1'b1, 9'h023, 32'h44332211, 4'h5, 1);
    do_req(1'b0, 9'h020, 32'h0, 4'h0, 5);
    do_req(1'b1, 9'h031, 32'h12345678, 4'h0, 2);
    do_req(1'b0, 9'h030, 32'h0, 4'h0, 0);

    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 9'h040;
    @(negedge CLK);
    chk("rst_case_accept", 32'(req_ready), 1);
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk_reset_outputs();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(negedge CLK);
    chk("req_ready_after_reset", 32'(req_ready), 1);
    repeat (10) begin
      @(negedge CLK);
      chk("no_rsp_after_reset", 32'(rsp_valid), 0);
      chk("no_we_after_reset", 32'(ram_we), 0);
    end
    @(posedge CLK);
    #1;

    do_req(1'b1, 9'h1FD, 32'hA1B2C3D4, 4'hF, 0);
    do_req(1'b0, 9'h1FC, 32'h0, 4'h0, 0);
    do_req(1'b0, 9'h000, 32'h0, 4'h0, 0);

    for (int r = 0; r < 30; r++) begin
      do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 511)),
             $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
